mem_arbiter: RTL and testbench
==============================

MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 The block SHALL have parameter ADDR_W, default 3, memory address width.
REQ-002 The block SHALL have parameter DATA_W, default 5, memory data width.
REQ-003 The block SHALL have one clock and a synchronous, active-high reset, named clk and rst.
REQ-004 clk  input  1  rising-edge clock for all state.
REQ-005 rst  input  1  synchronous active-high reset.
REQ-006 req0, req1  input  1 each  access request from requester 0 / 1.
REQ-007 we0, we1  input  1 each  1 = write, 0 = read, qualified by reqN.
REQ-008 addr0, addr1  input  ADDR_W each  request address.
REQ-009 wdata0, wdata1  input  DATA_W each  write data.
REQ-010 gnt0, gnt1  output  1 each  one-cycle grant pulse; request accepted.
REQ-011 rvalid0, rvalid1  output  1 each  one-cycle read-data-valid pulse.
REQ-012 rdata0, rdata1  output  DATA_W each  returned read data.
REQ-013 mem_addr  output  ADDR_W  to memory addr.
REQ-014 mem_rw  output  1  to memory rw (1 write, 0 read).
REQ-015 mem_o_en  output  1  to memory o_en.
REQ-016 mem_data_in  output  DATA_W  to memory data_in.
REQ-017 mem_data_out  input  DATA_W  from memory data_out; valid the cycle after a read command is presented.

Function
REQ-018 Arbitration SHALL occur at every rising edge over the eligible requests; eligible = reqN high and requester N not granted in the immediately preceding cycle.
REQ-019 Single eligible requester SHALL win; with both eligible, the requester other than the last winner SHALL win (round-robin); last winner resets to 1, so requester 0 wins first.
REQ-020 On a win at edge E0, the block SHALL drive, registered, from E0 for exactly one cycle: gntN=1, mem_addr=addrN, mem_data_in=wdataN, mem_rw=weN, mem_o_en=~weN.
REQ-021 With no winner, the block SHALL drive mem_rw=0, mem_o_en=0, gnt0=gnt1=0, and hold mem_addr and mem_data_in.
REQ-022 gnt0 and gnt1 SHALL never be high in the same cycle.
REQ-023 Requesters hold reqN, weN, addrN, wdataN stable until gntN is seen; a requester keeping reqN high after gntN presents a new request, eligible no earlier than the second edge after its grant.
REQ-024 A two-stage read-tag pipeline (valid, id) SHALL track each read; for a read granted at E0, mem_data_out SHALL be captured at E2, and rvalidN=1 with rdataN=captured data SHALL be output for the one cycle after E2 (gnt-to-rvalid latency 2 cycles).
REQ-025 Writes SHALL produce no rvalid pulse.
REQ-026 rdataN SHALL hold its last value when rvalidN=0; the non-target requester's rdata SHALL be unchanged.
REQ-027 Back-to-back alternating grants (0,1,0,1,...) SHALL sustain one memory access per cycle with in-order read returns.
REQ-028 A requester dropping reqN before grant SHALL not be granted; no state other than the last-winner pointer SHALL depend on it.

Reset
REQ-029 While rst=1 at an edge: gnt0/1=0, rvalid0/1=0, rdata0/1=0, mem_addr=0, mem_data_in=0, mem_rw=0, mem_o_en=0, read pipeline cleared, last winner=1, both requesters eligible.
REQ-030 Reset mid-operation SHALL discard in-flight reads: no rvalid is produced for any read granted before the reset edge.
REQ-031 Requests present during reset SHALL be ignored; arbitration resumes at the first edge with rst=0.

Verification
REQ-032 Write/read sweep: requester 0 alone writes data=i to addr i for i=0..7, then reads addr 0..7 -> gnt0 every second cycle, rvalid0 two cycles after each read gnt, rdata0=0..7 in order, gnt1 never high.
REQ-033 Contention: req0 and req1 both high from reset release, both reads (addr0=2, addr1=5, memory preloaded addr=value) -> gnt0, gnt1, gnt0, gnt1 on consecutive cycles; rvalid alternates 0,1,0,1 with rdata0=2, rdata1=5.
REQ-034 Mixed: requester 0 writes 17 to addr 3 while requester 1 reads addr 3 one cycle later -> no rvalid0; rvalid1 with rdata1=17.
REQ-035 Cooldown: req1 held high alone, addr1=4 -> gnt1 pattern 1,0,1,0; mem_o_en high only in gnt cycles; mem_rw=0 throughout.
REQ-036 Reset mid-read: rst asserted one cycle after a read gnt to addr 6 -> no rvalid in the following 3 cycles; all outputs at reset values; first post-reset grant goes to requester 0 when both request.

Source files
------------

// File: rtl/mem_arbiter.sv
// -----------------------------------------------------------------------------
// mem_arbiter
//   Two-requester round-robin arbiter in front of a single-port synchronous
//   memory. A winning request is presented to the memory as a one-cycle
//   registered command. Reads are tracked by a two-stage tag pipeline, so read
//   data returns on rvalidN/rdataN two cycles after the grant.
//
// Ports
//   clk, rst                   rising-edge clock, synchronous active-high reset
//   req0/1, we0/1              request strobe and write(1)/read(0) select
//   addr0/1, wdata0/1          request address and write data
//   gnt0/1                     one-cycle grant pulse (request accepted)
//   rvalid0/1, rdata0/1        one-cycle read-return pulse and held read data
//   mem_addr, mem_rw,          memory command (address, 1 = write,
//   mem_o_en, mem_data_in        output enable for reads, write data)
//   mem_data_out               memory read data, valid the cycle after a read
// -----------------------------------------------------------------------------
module mem_arbiter #(
  parameter int ADDR_W = 3,
  parameter int DATA_W = 5
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req0,
  input  logic              req1,
  input  logic              we0,
  input  logic              we1,
  input  logic [ADDR_W-1:0] addr0,
  input  logic [ADDR_W-1:0] addr1,
  input  logic [DATA_W-1:0] wdata0,
  input  logic [DATA_W-1:0] wdata1,
  output logic              gnt0,
  output logic              gnt1,
  output logic              rvalid0,
  output logic              rvalid1,
  output logic [DATA_W-1:0] rdata0,
  output logic [DATA_W-1:0] rdata1,
  output logic [ADDR_W-1:0] mem_addr,
  output logic              mem_rw,
  output logic              mem_o_en,
  output logic [DATA_W-1:0] mem_data_in,
  input  logic [DATA_W-1:0] mem_data_out
);

  logic              w_el0;
  logic              w_el1;
  logic              w_win;
  logic              w_win_id;
  logic              w_sel_we;
  logic [ADDR_W-1:0] w_sel_addr;
  logic [DATA_W-1:0] w_sel_wdata;

  // Id of the most recent winner; starts at 1 so requester 0 wins first.
  logic              r_last;
  // Read tag pipeline: stage 1 loads at the grant edge, stage 2 one edge later.
  logic              r_t1_valid;
  logic              r_t1_id;
  logic              r_t2_valid;
  logic              r_t2_id;

  // Eligibility, round-robin winner choice and request mux
  always_comb begin
    // A requester granted last cycle sits out one edge; its gnt register
    // is exactly that "granted last cycle" flag.
    w_el0 = req0 & ~gnt0;
    w_el1 = req1 & ~gnt1;
    w_win = w_el0 | w_el1;
    if (w_el0 && w_el1) begin
      w_win_id = ~r_last;
    end else if (w_el1) begin
      w_win_id = 1'b1;
    end else begin
      w_win_id = 1'b0;
    end
    if (w_win_id) begin
      w_sel_we    = we1;
      w_sel_addr  = addr1;
      w_sel_wdata = wdata1;
    end else begin
      w_sel_we    = we0;
      w_sel_addr  = addr0;
      w_sel_wdata = wdata0;
    end
  end

  // Grant pulses, memory command registers and last-winner pointer
  always_ff @(posedge clk) begin
    if (rst) begin
      gnt0        <= 1'b0;
      gnt1        <= 1'b0;
      mem_addr    <= {ADDR_W{1'b0}};
      mem_data_in <= {DATA_W{1'b0}};
      mem_rw      <= 1'b0;
      mem_o_en    <= 1'b0;
      r_last      <= 1'b1;
    end else if (w_win) begin
      gnt0        <= ~w_win_id;
      gnt1        <= w_win_id;
      mem_addr    <= w_sel_addr;
      mem_data_in <= w_sel_wdata;
      mem_rw      <= w_sel_we;
      mem_o_en    <= ~w_sel_we;
      r_last      <= w_win_id;
    end else begin
      // Idle cycle: strobes drop, address and write data hold.
      gnt0        <= 1'b0;
      gnt1        <= 1'b0;
      mem_rw      <= 1'b0;
      mem_o_en    <= 1'b0;
    end
  end

  // Read tag pipeline and read-data return registers
  always_ff @(posedge clk) begin
    if (rst) begin
      r_t1_valid <= 1'b0;
      r_t1_id    <= 1'b0;
      r_t2_valid <= 1'b0;
      r_t2_id    <= 1'b0;
      rvalid0    <= 1'b0;
      rvalid1    <= 1'b0;
      rdata0     <= {DATA_W{1'b0}};
      rdata1     <= {DATA_W{1'b0}};
    end else begin
      r_t1_valid <= w_win & ~w_sel_we;
      r_t1_id    <= w_win_id;
      r_t2_valid <= r_t1_valid;
      r_t2_id    <= r_t1_id;
      rvalid0    <= r_t2_valid & ~r_t2_id;
      rvalid1    <= r_t2_valid & r_t2_id;
      // Memory data for the stage-2 tag has been stable since the last edge.
      if (r_t2_valid && !r_t2_id) begin
        rdata0 <= mem_data_out;
      end
      if (r_t2_valid && r_t2_id) begin
        rdata1 <= mem_data_out;
      end
    end
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// -----------------------------------------------------------------------------
// tb_mem_arbiter
//   Directed self-checking bench for mem_arbiter with a small synchronous
//   memory model (read data appears the cycle after o_en is presented).
// -----------------------------------------------------------------------------
module tb_mem_arbiter;
  localparam int AW = 3;
  localparam int DW = 5;

  logic          clk = 1'b0;
  logic          rst;
  logic          req0, req1, we0, we1;
  logic [AW-1:0] addr0, addr1;
  logic [DW-1:0] wdata0, wdata1;
  logic          gnt0, gnt1, rvalid0, rvalid1;
  logic [DW-1:0] rdata0, rdata1;
  logic [AW-1:0] mem_addr;
  logic          mem_rw, mem_o_en;
  logic [DW-1:0] mem_data_in;
  logic [DW-1:0] mem_data_out;

  int n_checks = 0;
  int n_fail   = 0;

  logic          preload;
  logic [DW-1:0] mem [8];

  mem_arbiter #(.ADDR_W(AW), .DATA_W(DW)) dut (
    .clk(clk), .rst(rst),
    .req0(req0), .req1(req1), .we0(we0), .we1(we1),
    .addr0(addr0), .addr1(addr1), .wdata0(wdata0), .wdata1(wdata1),
    .gnt0(gnt0), .gnt1(gnt1), .rvalid0(rvalid0), .rvalid1(rvalid1),
    .rdata0(rdata0), .rdata1(rdata1),
    .mem_addr(mem_addr), .mem_rw(mem_rw), .mem_o_en(mem_o_en),
    .mem_data_in(mem_data_in), .mem_data_out(mem_data_out)
  );

  always #5 clk = ~clk;

  // Memory model; the preload pattern differs from what the sweep writes.
  always @(posedge clk) begin
    if (preload) begin
      for (int k = 0; k < 8; k++) mem[k] <= DW'(31 - k);
    end else begin
      if (mem_o_en) mem_data_out <= mem[mem_addr];
      if (mem_rw) mem[mem_addr] <= mem_data_in;
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    logic [5:0] got;
    rst = 1'b1; preload = 1'b1;
    req0 = 1'b1; req1 = 1'b1; we0 = 1'b1; we1 = 1'b0;
    addr0 = 3'd5; addr1 = 3'd6; wdata0 = 5'd9; wdata1 = 5'd3;
    step();
    preload = 1'b0;
    step();
    got = {gnt0, gnt1, rvalid0, rvalid1, mem_rw, mem_o_en};
    n_checks++;
    if (got !== 6'b000000) begin
      n_fail++; $display("FAIL reset_ctrl got %b exp %b", got, 6'b000000);
    end
    n_checks++;
    if ({rdata0, rdata1} !== 10'd0) begin
      n_fail++; $display("FAIL reset_rdata got %h/%h exp 0/0", rdata0, rdata1);
    end
    n_checks++;
    if ({mem_addr, mem_data_in} !== 8'd0) begin
      n_fail++; $display("FAIL reset_mem got %h/%h exp 0/0", mem_addr, mem_data_in);
    end
    rst = 1'b0; req0 = 1'b0; req1 = 1'b0;
    step();
    got = {gnt0, gnt1, rvalid0, rvalid1, mem_rw, mem_o_en};
    n_checks++;
    if (got !== 6'b000000) begin
      n_fail++; $display("FAIL reset_release_idle got %b exp %b", got, 6'b000000);
    end
  endtask

  task automatic test_sweep();
    logic [4:0] got;
    logic [4:0] exp;
    req0 = 1'b1; we0 = 1'b1; addr0 = 3'd0; wdata0 = 5'd0; req1 = 1'b0;
    for (int i = 0; i < 8; i++) begin
      step();
      got = {gnt0, gnt1, mem_rw, mem_o_en, rvalid0};
      n_checks++;
      if (got !== 5'b10100) begin
        n_fail++; $display("FAIL sweep_wr_gnt i=%0d got %b exp %b", i, got, 5'b10100);
      end
      n_checks++;
      if (mem_addr !== AW'(i) || mem_data_in !== DW'(i)) begin
        n_fail++; $display("FAIL sweep_wr_cmd i=%0d got %0d/%0d exp %0d/%0d", i, mem_addr, mem_data_in, i, i);
      end
      if (i == 7) begin
        we0 = 1'b0; addr0 = 3'd0;
      end else begin
        addr0 = AW'(i + 1); wdata0 = DW'(i + 1);
      end
      step();
      got = {gnt0, gnt1, mem_rw, mem_o_en, rvalid0};
      n_checks++;
      if (got !== 5'b00000) begin
        n_fail++; $display("FAIL sweep_wr_gap i=%0d got %b exp %b", i, got, 5'b00000);
      end
    end
    for (int i = 0; i < 8; i++) begin
      step();
      exp = {4'b1001, (i > 0) ? 1'b1 : 1'b0};
      got = {gnt0, gnt1, mem_rw, mem_o_en, rvalid0};
      n_checks++;
      if (got !== exp) begin
        n_fail++; $display("FAIL sweep_rd_gnt i=%0d got %b exp %b", i, got, exp);
      end
      n_checks++;
      if (mem_addr !== AW'(i)) begin
        n_fail++; $display("FAIL sweep_rd_addr i=%0d got %0d exp %0d", i, mem_addr, i);
      end
      if (i > 0) begin
        n_checks++;
        if (rdata0 !== DW'(i - 1)) begin
          n_fail++; $display("FAIL sweep_rdata i=%0d got %0d exp %0d", i, rdata0, i - 1);
        end
      end
      if (i == 7) req0 = 1'b0;
      else addr0 = AW'(i + 1);
      step();
      got = {gnt0, gnt1, mem_rw, mem_o_en, rvalid0};
      n_checks++;
      if (got !== 5'b00000) begin
        n_fail++; $display("FAIL sweep_rd_gap i=%0d got %b exp %b", i, got, 5'b00000);
      end
    end
    step();
    n_checks++;
    if ({gnt0, gnt1, rvalid0, rvalid1} !== 4'b0010 || rdata0 !== 5'd7) begin
      n_fail++; $display("FAIL sweep_last_rd got %b%b%b%b/%0d exp 0010/7", gnt0, gnt1, rvalid0, rvalid1, rdata0);
    end
    step();
    n_checks++;
    if (rvalid0 !== 1'b0 || rdata0 !== 5'd7) begin
      n_fail++; $display("FAIL sweep_hold got %b/%0d exp 0/7", rvalid0, rdata0);
    end
  endtask

  task automatic test_contention();
    logic [4:0] tab [7];
    logic [2:0] atab [7];
    logic [4:0] got;
    tab  = '{5'b10100, 5'b01100, 5'b10110, 5'b01101, 5'b00010, 5'b00001, 5'b00000};
    atab = '{3'd2, 3'd5, 3'd2, 3'd5, 3'd5, 3'd5, 3'd5};
    req0 = 1'b1; req1 = 1'b1; we0 = 1'b0; we1 = 1'b0; addr0 = 3'd2; addr1 = 3'd5;
    rst = 1'b1;
    step();
    rst = 1'b0;
    for (int s = 0; s < 7; s++) begin
      step();
      got = {gnt0, gnt1, mem_o_en, rvalid0, rvalid1};
      n_checks++;
      if (got !== tab[s]) begin
        n_fail++; $display("FAIL contention_ctrl s=%0d got %b exp %b", s, got, tab[s]);
      end
      n_checks++;
      if (mem_addr !== atab[s]) begin
        n_fail++; $display("FAIL contention_addr s=%0d got %0d exp %0d", s, mem_addr, atab[s]);
      end
      if (s >= 3) begin
        n_checks++;
        if (rdata0 !== 5'd2 || rdata1 !== 5'd5) begin
          n_fail++; $display("FAIL contention_rdata s=%0d got %0d/%0d exp 2/5", s, rdata0, rdata1);
        end
      end
      if (s == 3) begin
        req0 = 1'b0; req1 = 1'b0;
      end
    end
  endtask

  task automatic test_mixed();
    req0 = 1'b1; we0 = 1'b1; addr0 = 3'd3; wdata0 = 5'd17;
    req1 = 1'b0; we1 = 1'b0; addr1 = 3'd3;
    step();
    n_checks++;
    if ({gnt0, gnt1, mem_rw, mem_o_en} !== 4'b1010 || mem_addr !== 3'd3 || mem_data_in !== 5'd17) begin
      n_fail++; $display("FAIL mixed_wr got %b%b%b%b %0d/%0d exp 1010 3/17", gnt0, gnt1, mem_rw, mem_o_en, mem_addr, mem_data_in);
    end
    req0 = 1'b0; req1 = 1'b1;
    step();
    n_checks++;
    if ({gnt0, gnt1, mem_rw, mem_o_en} !== 4'b0101 || mem_addr !== 3'd3) begin
      n_fail++; $display("FAIL mixed_rd got %b%b%b%b %0d exp 0101 3", gnt0, gnt1, mem_rw, mem_o_en, mem_addr);
    end
    req1 = 1'b0;
    step();
    n_checks++;
    if ({rvalid0, rvalid1} !== 2'b00) begin
      n_fail++; $display("FAIL mixed_no_wr_rvalid got %b exp 00", {rvalid0, rvalid1});
    end
    step();
    n_checks++;
    if ({rvalid0, rvalid1} !== 2'b01 || rdata1 !== 5'd17 || rdata0 !== 5'd2) begin
      n_fail++; $display("FAIL mixed_rvalid1 got %b %0d/%0d exp 01 2/17", {rvalid0, rvalid1}, rdata0, rdata1);
    end
    step();
    n_checks++;
    if ({rvalid0, rvalid1} !== 2'b00 || rdata1 !== 5'd17) begin
      n_fail++; $display("FAIL mixed_hold got %b %0d exp 00 17", {rvalid0, rvalid1}, rdata1);
    end
  endtask

  task automatic test_cooldown();
    logic [4:0] tab [6];
    logic [4:0] got;
    tab = '{5'b01010, 5'b00000, 5'b01011, 5'b00000, 5'b00001, 5'b00000};
    req0 = 1'b0; req1 = 1'b1; we1 = 1'b0; addr1 = 3'd4;
    for (int s = 0; s < 6; s++) begin
      step();
      got = {gnt0, gnt1, mem_rw, mem_o_en, rvalid1};
      n_checks++;
      if (got !== tab[s]) begin
        n_fail++; $display("FAIL cooldown_ctrl s=%0d got %b exp %b", s, got, tab[s]);
      end
      if (s == 2 || s == 4) begin
        n_checks++;
        if (rdata1 !== 5'd4) begin
          n_fail++; $display("FAIL cooldown_rdata s=%0d got %0d exp 4", s, rdata1);
        end
      end
      if (s == 3) req1 = 1'b0;
    end
  endtask

  task automatic test_reset_mid_read();
    logic [5:0] got;
    req0 = 1'b1; we0 = 1'b0; addr0 = 3'd6; req1 = 1'b0;
    step();
    n_checks++;
    if ({gnt0, gnt1, mem_o_en} !== 3'b101 || mem_addr !== 3'd6) begin
      n_fail++; $display("FAIL midrst_gnt got %b%b%b %0d exp 101 6", gnt0, gnt1, mem_o_en, mem_addr);
    end
    req0 = 1'b0; rst = 1'b1;
    step();
    got = {gnt0, gnt1, rvalid0, rvalid1, mem_rw, mem_o_en};
    n_checks++;
    if (got !== 6'b000000 || {rdata0, rdata1} !== 10'd0 || {mem_addr, mem_data_in} !== 8'd0) begin
      n_fail++; $display("FAIL midrst_outputs got %b %0d/%0d %0d/%0d exp all 0", got, rdata0, rdata1, mem_addr, mem_data_in);
    end
    rst = 1'b0;
    for (int s = 0; s < 2; s++) begin
      step();
      n_checks++;
      if ({rvalid0, rvalid1, gnt0, gnt1} !== 4'b0000) begin
        n_fail++; $display("FAIL midrst_no_rvalid s=%0d got %b exp 0000", s, {rvalid0, rvalid1, gnt0, gnt1});
      end
    end
    req0 = 1'b1; req1 = 1'b1; we0 = 1'b0; we1 = 1'b0; addr0 = 3'd1; addr1 = 3'd7;
    step();
    n_checks++;
    if ({gnt0, gnt1} !== 2'b10) begin
      n_fail++; $display("FAIL midrst_first_gnt got %b exp 10", {gnt0, gnt1});
    end
    req0 = 1'b0;
    step();
    n_checks++;
    if ({gnt0, gnt1} !== 2'b01) begin
      n_fail++; $display("FAIL midrst_second_gnt got %b exp 01", {gnt0, gnt1});
    end
    req1 = 1'b0;
    step();
    n_checks++;
    if ({rvalid0, rvalid1} !== 2'b10 || rdata0 !== 5'd1) begin
      n_fail++; $display("FAIL midrst_rvalid0 got %b %0d exp 10 1", {rvalid0, rvalid1}, rdata0);
    end
    step();
    n_checks++;
    if ({rvalid0, rvalid1} !== 2'b01 || rdata1 !== 5'd7) begin
      n_fail++; $display("FAIL midrst_rvalid1 got %b %0d exp 01 7", {rvalid0, rvalid1}, rdata1);
    end
  endtask

  initial begin
    rst = 1'b1; preload = 1'b1;
    req0 = 1'b0; req1 = 1'b0; we0 = 1'b0; we1 = 1'b0;
    addr0 = 3'd0; addr1 = 3'd0; wdata0 = 5'd0; wdata1 = 5'd0;
    test_reset();
    test_sweep();
    test_contention();
    test_mixed();
    test_cooldown();
    test_reset_mid_read();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
